// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text console writer.
// Optional clear-screen-on-FF support is enabled with TEXT_WRITER_CLS_EN.
package text_pkg;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BLANK    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor register {row, col} with increment, decrement, carriage return,
// line feed and zero controls; all arithmetic is modulo the field widths.
module text_cursor #(
    parameter int COLS = 16,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          cr,
    input  logic          lf,
    input  logic          zero,
    output logic [AW-1:0] cursor,
    output logic [AW-1:0] cursor_dec
);
    localparam int CW = $clog2(COLS);
    localparam int RW = AW - CW;

    logic [AW-1:0] cursor_q, cursor_d;

    // LF only touches the row slice so the column survives and the row wraps.
    always_comb begin
        cursor_d = cursor_q;
        if (zero)
            cursor_d = '0;
        else if (inc)
            cursor_d = cursor_q + AW'(1);
        else if (dec)
            cursor_d = cursor_q - AW'(1);
        else if (cr)
            cursor_d[CW-1:0] = '0;
        else if (lf)
            cursor_d[AW-1:CW] = cursor_q[AW-1:CW] + RW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cursor_q <= '0;
        else
            cursor_q <= cursor_d;
    end

    assign cursor     = cursor_q;
    assign cursor_dec = cursor_q - AW'(1);

endmodule

// File: rtl/text_writer.sv
// Byte-stream console front end driving a tile RAM write port; clears the
// screen after reset. Define TEXT_WRITER_CLS_EN to make FF re-run the clear.
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS  = 16,
    parameter int         ROWS  = 8,
    parameter int         AW    = 7,
    parameter logic [7:0] BLANK = CH_BLANK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          we,
    output logic [AW-1:0] cursor,
    output logic          busy
);
    localparam logic [AW-1:0] LAST = AW'(COLS * ROWS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          rx_ready_q, rx_ready_d;
    logic          busy_q, busy_d;

    logic          cur_inc, cur_dec, cur_cr, cur_lf, cur_zero;
    logic [AW-1:0] cur, cur_dec_val;
    logic          accept;

    text_cursor #(.COLS(COLS), .AW(AW)) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .inc        (cur_inc),
        .dec        (cur_dec),
        .cr         (cur_cr),
        .lf         (cur_lf),
        .zero       (cur_zero),
        .cursor     (cur),
        .cursor_dec (cur_dec_val)
    );

    // rx_ready_q mirrors state_q==ST_IDLE, so it doubles as the accept gate.
    assign accept = rx_valid && rx_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        rx_ready_d = rx_ready_q;
        busy_d     = busy_q;
        cur_inc    = 1'b0;
        cur_dec    = 1'b0;
        cur_cr     = 1'b0;
        cur_lf     = 1'b0;
        cur_zero   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = BLANK;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d    = ST_IDLE;
                    rx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    cur_zero   = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (is_printable(rx_data)) begin
                        we_d    = 1'b1;
                        waddr_d = cur;
                        wdata_d = rx_data;
                        cur_inc = 1'b1;
                    end else if (rx_data == CH_CR) begin
                        cur_cr = 1'b1;
                    end else if (rx_data == CH_LF) begin
                        cur_lf = 1'b1;
                    end else if (rx_data == CH_BS) begin
                        we_d    = 1'b1;
                        waddr_d = cur_dec_val;
                        wdata_d = BLANK;
                        cur_dec = 1'b1;
                    end
`ifdef TEXT_WRITER_CLS_EN
                    else if (rx_data == CH_FF) begin
                        state_d    = ST_CLEAR;
                        cnt_d      = '0;
                        rx_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= BLANK;
            we_q       <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign we       = we_q;
    assign cursor   = cur;
    assign busy     = busy_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: a per-cycle reference model of the console
// plus literal expectations for the sweep, CR/LF/BS, wrap and FF cases.
module tb_text_writer;
    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int AW   = 7;
    localparam int N    = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          we;
    logic [AW-1:0] cursor;
    logic          busy;

    int errors = 0;
    int checks = 0;

    text_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .BLANK(8'h20)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .waddr    (waddr),
        .wdata    (wdata),
        .we       (we),
        .cursor   (cursor),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: console state as plain integers, cursor = row*COLS+col.
    bit chk_en = 1'b0;
    bit m_clearing;
    int m_cnt, m_cursor, m_waddr;
    bit m_we, m_ready, m_busy;
    logic [7:0] m_wdata;

    always @(posedge clk) begin
        if (rst) begin
            chk_en = 1'b1;
            m_clearing = 1'b1; m_cnt = 0; m_cursor = 0;
            m_we = 1'b0; m_waddr = 0; m_wdata = 8'h20; m_ready = 1'b0; m_busy = 1'b1;
        end else if (m_clearing) begin
            m_we = 1'b1; m_waddr = m_cnt; m_wdata = 8'h20;
            m_cnt++;
            if (m_cnt == N) begin
                m_clearing = 1'b0; m_ready = 1'b1; m_busy = 1'b0; m_cursor = 0;
            end
        end else begin
            m_we = 1'b0;
            if (rx_valid && m_ready) begin
                if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                    m_we = 1'b1; m_waddr = m_cursor; m_wdata = rx_data;
                    m_cursor = (m_cursor + 1) % N;
                end else if (rx_data == 8'h0D) begin
                    m_cursor = (m_cursor / COLS) * COLS;
                end else if (rx_data == 8'h0A) begin
                    m_cursor = (((m_cursor / COLS) + 1) % ROWS) * COLS + (m_cursor % COLS);
                end else if (rx_data == 8'h08) begin
                    m_cursor = (m_cursor + N - 1) % N;
                    m_we = 1'b1; m_waddr = m_cursor; m_wdata = 8'h20;
                end
`ifdef TEXT_WRITER_CLS_EN
                else if (rx_data == 8'h0C) begin
                    m_clearing = 1'b1; m_cnt = 0; m_ready = 1'b0; m_busy = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_we", we, m_we);
            chk("m_waddr", waddr, m_waddr);
            chk("m_wdata", wdata, m_wdata);
            chk("m_cursor", cursor, m_cursor);
            chk("m_rx_ready", rx_ready, m_ready);
            chk("m_busy", busy, m_busy);
        end
    end

    // Called at a negedge; returns at the negedge where the byte's effect shows.
    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Counts we pulses until rx_ready rises, bounded.
    task automatic wait_sweep(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (we === 1'b1) n++;
            if (rx_ready === 1'b1) break;
        end
        chk("sweep_done", rx_ready, 1);
    endtask

    int n;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", rx_ready, 0);
        chk("rst_wdata", wdata, 8'h20);
        rst = 1'b0;
        wait_sweep(n);
        chk("sweep_len", n, 128);
        chk("sweep_last_addr", waddr, 127);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_cursor", cursor, 0);
        chk("idle_we", we, 0);

        // "AB" back-to-back
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk);
        chk("A_we", we, 1); chk("A_addr", waddr, 0); chk("A_data", wdata, 8'h41);
        rx_data = 8'h42;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("B_we", we, 1); chk("B_addr", waddr, 1); chk("B_data", wdata, 8'h42);
        chk("AB_cursor", cursor, 2);

        // Reach 20 (row 1, col 4), then CR and LF
        send(8'h0A); chk("lf_18", cursor, 18);
        send(8'h78); send(8'h79);
        chk("pos_20", cursor, 20);
        send(8'h0D); chk("cr_cursor", cursor, 16); chk("cr_we", we, 0);
        send(8'h0A); chk("lf_cursor", cursor, 32); chk("lf_we", we, 0);

        // Reach 127, then wrap with 'Z'
        repeat (5) send(8'h0A);
        chk("row7", cursor, 112);
        repeat (15) send(8'h61);
        chk("pos_127", cursor, 127);
        send(8'h5A);
        chk("Z_we", we, 1); chk("Z_addr", waddr, 127); chk("Z_data", wdata, 8'h5A);
        chk("Z_wrap", cursor, 0);

        // BS at 0 wraps back to 127
        send(8'h08);
        chk("bs_we", we, 1); chk("bs_addr", waddr, 127); chk("bs_data", wdata, 8'h20);
        chk("bs_cursor", cursor, 127);

        // Reset mid-sweep
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_we_sweeping", we, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", we, 0);
        @(negedge clk);
        chk("mid_rst_we2", we, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_addr", waddr, 0); chk("restart_we", we, 1);
        wait_sweep(n);
        chk("restart_len", n, 127);
        @(negedge clk);
        chk("restart_cursor", cursor, 0);

        // Unknown control byte
        send(8'h61); send(8'h61);
        send(8'h01);
        chk("ctl_we", we, 0); chk("ctl_cursor", cursor, 2); chk("ctl_ready", rx_ready, 1);

        // Reach 40, then FF
        send(8'h0A); send(8'h0A);
        chk("pos_34", cursor, 34);
        repeat (6) send(8'h62);
        chk("pos_40", cursor, 40);
        send(8'h0C);
`ifdef TEXT_WRITER_CLS_EN
        chk("ff_ready", rx_ready, 0); chk("ff_busy", busy, 1); chk("ff_we", we, 0);
        wait_sweep(n);
        chk("ff_sweep_len", n, 128);
        @(negedge clk);
        chk("ff_cursor", cursor, 0);
`else
        chk("ff_ready", rx_ready, 1); chk("ff_we", we, 0); chk("ff_cursor", cursor, 40);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
